// File: rtl/heartrate_meter_pkg.sv
// heartrate_meter_pkg: shared definitions for the heartbeat tick measurement blocks.
//   - FSM state encodings (IDLE, MEASURE, LOCKED, LOST)
//   - period window / timeout derivation helpers (PMIN, PMAX, TMAX)
//   - period history depth used when HEARTRATE_METER_AVG_EN is defined
package heartrate_meter_pkg;

  // FSM state encodings, shared with future tick-related blocks
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_LOST    = 2'd3;

  // Depth of the optional period history (averaging divides by shifting)
  localparam int unsigned HIST_DEPTH = 4;

  // Expected period in clock cycles
  function automatic int unsigned calc_exp(input int unsigned clk_hz,
                                           input int unsigned exp_hz);
    return clk_hz / exp_hz;
  endfunction

  // Lower bound of the acceptable period window (truncating)
  function automatic int unsigned calc_pmin(input int unsigned exp_cyc,
                                            input int unsigned tol_pct);
    return 32'((64'(exp_cyc) * 64'(100 - tol_pct)) / 64'd100);
  endfunction

  // Upper bound of the acceptable period window (truncating)
  function automatic int unsigned calc_pmax(input int unsigned exp_cyc,
                                            input int unsigned tol_pct);
    return 32'((64'(exp_cyc) * 64'(100 + tol_pct)) / 64'd100);
  endfunction

  // Cycles without a beat before the stream is declared lost
  function automatic int unsigned calc_tmax(input int unsigned clk_hz,
                                            input int unsigned min_hz);
    return clk_hz / min_hz;
  endfunction

endpackage

// File: rtl/heartrate_meter_sync_edge.sv
// heartrate_meter_sync_edge: 2-FF synchronizer plus rising-edge detector.
// A high level of any length on async_in yields exactly one registered beat.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous, active-high reset
//   async_in in  asynchronous pulse input
//   beat     out one-cycle strobe per rising edge of async_in (registered)
module heartrate_meter_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic beat
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic beat_q, beat_d;

  // Synchronizer shift, history stage and edge detect
  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    beat_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      beat_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/heartrate_meter.sv
// heartrate_meter: measures the period of an incoming pulse stream in clock
// cycles, checks it against EXP_HZ +/- TOL_PCT and flags loss of the stream
// after TMAX cycles without a beat.
// Optional feature macro: HEARTRATE_METER_AVG_EN (period output becomes the
// truncated mean of the last 4 raw periods; in_range/locked stay raw).
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  asynchronous, active-high reset
//   pulse_in     in  asynchronous pulse stream, each rising edge is a beat
//   period       out last measured (or averaged) period in cycles
//   period_valid out one-cycle strobe when period/in_range update
//   in_range     out last raw period within [PMIN, PMAX]
//   locked       out stream present and last period in range
//   timeout      out no beat for TMAX cycles
module heartrate_meter
  import heartrate_meter_pkg::*;
#(
  parameter  int unsigned CLK_HZ  = 12000000,
  parameter  int unsigned EXP_HZ  = 1,
  parameter  int unsigned TOL_PCT = 10,
  parameter  int unsigned MIN_HZ  = 1,
  localparam int unsigned N       = $clog2(calc_tmax(CLK_HZ, MIN_HZ) + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         in_range,
  output logic         locked,
  output logic         timeout
);

  localparam int unsigned EXP  = calc_exp(CLK_HZ, EXP_HZ);
  localparam int unsigned PMIN = calc_pmin(EXP, TOL_PCT);
  localparam int unsigned PMAX = calc_pmax(EXP, TOL_PCT);
  localparam int unsigned TMAX = calc_tmax(CLK_HZ, MIN_HZ);

  logic         beat;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         period_valid_q, period_valid_d;
  logic         in_range_q, in_range_d;
  logic         locked_q, locked_d;
  logic         timeout_q, timeout_d;

  logic         cnt_sat_c;
  logic         cnt_in_range_c;
  logic         strobe_c;

  // Beat extraction from the asynchronous pulse stream
  heartrate_meter_sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (pulse_in),
    .beat     (beat)
  );

  assign cnt_sat_c      = (cnt_q == N'(TMAX));
  assign cnt_in_range_c = (cnt_q >= N'(PMIN)) && (cnt_q <= N'(PMAX));

  // Cycle counter: restarts at 1 on a beat so it equals the beat spacing
  always_comb begin
    cnt_d = cnt_q;
    if (beat) begin
      cnt_d = N'(1);
    end else if (!cnt_sat_c) begin
      cnt_d = cnt_q + N'(1);
    end
  end

  // Next-state and registered output logic; a beat wins over saturation
  always_comb begin
    state_d        = state_q;
    strobe_c       = 1'b0;
    in_range_d     = in_range_q;
    case (state_q)
      ST_IDLE, ST_LOST: begin
        if (beat) begin
          state_d = ST_MEASURE;
        end else if (cnt_sat_c) begin
          state_d = ST_LOST;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (beat) begin
          strobe_c   = 1'b1;
          in_range_d = cnt_in_range_c;
          state_d    = cnt_in_range_c ? ST_LOCKED : ST_MEASURE;
        end else if (cnt_sat_c) begin
          state_d = ST_LOST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    period_valid_d = strobe_c;
    locked_d       = (state_d == ST_LOCKED);
    timeout_d      = (state_d == ST_LOST);
  end

`ifdef HEARTRATE_METER_AVG_EN
  localparam int unsigned SW = N + 2;

  logic [N-1:0]  hist_q [HIST_DEPTH];
  logic [N-1:0]  hist_d [HIST_DEPTH];
  logic          fill_q, fill_d;
  logic          restart_c;
  logic [SW-1:0] sum_c;

  assign restart_c = beat && ((state_q == ST_IDLE) || (state_q == ST_LOST));

  // History update: the first period after a restart fills every entry
  always_comb begin
    fill_d = fill_q;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hist_d[i] = hist_q[i];
    end
    if (restart_c) begin
      fill_d = 1'b1;
    end
    if (strobe_c) begin
      fill_d = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        if (fill_q || (i == 0)) begin
          hist_d[i] = cnt_q;
        end else begin
          hist_d[i] = hist_q[i-1];
        end
      end
    end
    sum_c = SW'(hist_d[0]) + SW'(hist_d[1]) + SW'(hist_d[2]) + SW'(hist_d[3]);
    period_d = strobe_c ? sum_c[SW-1:2] : period_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= 1'b1;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end
`else
  // Raw period captured on each strobe, held otherwise
  always_comb begin
    period_d = strobe_c ? cnt_q : period_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
